// File: rtl/elbeth_load_store_unit.sv
// Load/store initiator for one ELBETH 32-bit memory port: aligns store lanes, extracts and
// extends load lanes, and turns misaligned/illegal requests or a silent memory into an error pulse.
module elbeth_load_store_unit #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [1:0]            cpu_size,
  input  logic                  cpu_unsigned,
  input  logic [ADDR_WIDTH+1:0] cpu_addr,
  input  logic [31:0]           cpu_wdata,
  output logic                  cpu_busy,
  output logic                  cpu_done,
  output logic                  cpu_error,
  output logic [31:0]           cpu_rdata,
  output logic                  mem_enable,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_data_in,
  output logic [3:0]            mem_wr,
  input  logic [31:0]           mem_data_out,
  input  logic                  mem_ready
);

  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {StIdle, StAccess, StFault} state_t;

  state_t           state;
  logic [1:0]       size_q;
  logic             uns_q;
  logic             we_q;
  logic [1:0]       off_q;
  logic [CNT_W-1:0] tmo_cnt;

  logic [1:0]  off;
  logic        req_fault;
  logic [3:0]  req_wr;
  logic [31:0] req_wdata;
  logic [31:0] lane;
  logic [31:0] load_data;

  assign off = cpu_addr[1:0];

  // Store lanes are replicated so the memory only has to honour mem_wr.
  always_comb begin
    req_fault = 1'b0;
    req_wr    = 4'b0000;
    req_wdata = 32'h0;
    case (cpu_size)
      2'b00: begin
        req_wr    = 4'b0001 << off;
        req_wdata = {4{cpu_wdata[7:0]}};
      end
      2'b01: begin
        req_fault = off[0];
        req_wr    = 4'b0011 << off;
        req_wdata = {2{cpu_wdata[15:0]}};
      end
      2'b10: begin
        req_fault = (off != 2'b00);
        req_wr    = 4'b1111;
        req_wdata = cpu_wdata;
      end
      default: req_fault = 1'b1;
    endcase
    if (!cpu_we) begin
      req_wr    = 4'b0000;
      req_wdata = 32'h0;
    end
  end

  assign lane = mem_data_out >> {off_q, 3'b000};

  always_comb begin
    case (size_q)
      2'b00:   load_data = uns_q ? {24'h0, lane[7:0]} : {{24{lane[7]}}, lane[7:0]};
      2'b01:   load_data = uns_q ? {16'h0, lane[15:0]} : {{16{lane[15]}}, lane[15:0]};
      default: load_data = mem_data_out;
    endcase
  end

  assign cpu_busy   = (state != StIdle);
  assign mem_enable = (state == StAccess);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= StIdle;
      cpu_done    <= 1'b0;
      cpu_error   <= 1'b0;
      cpu_rdata   <= 32'h0;
      mem_addr    <= '0;
      mem_wr      <= 4'b0000;
      mem_data_in <= 32'h0;
      size_q      <= 2'b00;
      uns_q       <= 1'b0;
      we_q        <= 1'b0;
      off_q       <= 2'b00;
      tmo_cnt     <= '0;
    end else begin
      cpu_done  <= 1'b0;
      cpu_error <= 1'b0;
      case (state)
        StIdle: begin
          if (cpu_req) begin
            if (req_fault) begin
              cpu_error <= 1'b1;
              state     <= StFault;
            end else begin
              mem_addr    <= cpu_addr[ADDR_WIDTH+1:2];
              mem_wr      <= req_wr;
              mem_data_in <= req_wdata;
              size_q      <= cpu_size;
              uns_q       <= cpu_unsigned;
              we_q        <= cpu_we;
              off_q       <= off;
              tmo_cnt     <= '0;
              state       <= StAccess;
            end
          end
        end
        StAccess: begin
          // A ready on the last permitted edge still completes the access.
          if (mem_ready) begin
            cpu_done <= 1'b1;
            if (!we_q) cpu_rdata <= load_data;
            state <= StIdle;
          end else if ((TIMEOUT != 0) && (tmo_cnt == TMO_LAST)) begin
            cpu_error <= 1'b1;
            state     <= StFault;
          end else begin
            tmo_cnt <= tmo_cnt + CNT_W'(1);
          end
        end
        StFault: state <= StIdle;
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_elbeth_load_store_unit.sv
// Directed bench for elbeth_load_store_unit with a small word memory and programmable wait states.
module tb_elbeth_load_store_unit;

  logic        clk;
  logic        rst;
  logic        cpu_req;
  logic        cpu_we;
  logic [1:0]  cpu_size;
  logic        cpu_unsigned;
  logic [9:0]  cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_busy;
  logic        cpu_done;
  logic        cpu_error;
  logic [31:0] cpu_rdata;
  logic        mem_enable;
  logic [7:0]  mem_addr;
  logic [31:0] mem_data_in;
  logic [3:0]  mem_wr;
  logic [31:0] mem_data_out;
  logic        mem_ready;

  int passed;
  int total;

  // Memory model: ready comes ready_delay cycles after enable rises unless stalled.
  logic [31:0] mem [256];
  logic        mem_clear;
  logic        mem_stall;
  int          ready_delay;
  int          wcnt;

  assign mem_data_out = mem[mem_addr];
  assign mem_ready    = mem_enable && !mem_stall && (wcnt == ready_delay);

  always @(posedge clk) begin
    wcnt <= mem_enable ? wcnt + 1 : 0;
    if (mem_clear) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
    end else if (mem_enable && mem_ready) begin
      for (int i = 0; i < 4; i++)
        if (mem_wr[i]) mem[mem_addr][8*i +: 8] <= mem_data_in[8*i +: 8];
    end
  end

  elbeth_load_store_unit #(
    .ADDR_WIDTH(8),
    .TIMEOUT   (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cpu_req     (cpu_req),
    .cpu_we      (cpu_we),
    .cpu_size    (cpu_size),
    .cpu_unsigned(cpu_unsigned),
    .cpu_addr    (cpu_addr),
    .cpu_wdata   (cpu_wdata),
    .cpu_busy    (cpu_busy),
    .cpu_done    (cpu_done),
    .cpu_error   (cpu_error),
    .cpu_rdata   (cpu_rdata),
    .mem_enable  (mem_enable),
    .mem_addr    (mem_addr),
    .mem_data_in (mem_data_in),
    .mem_wr      (mem_wr),
    .mem_data_out(mem_data_out),
    .mem_ready   (mem_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_req(input logic we, input logic [1:0] size, input logic uns,
                           input logic [9:0] addr, input logic [31:0] wdata);
    cpu_we       = we;
    cpu_size     = size;
    cpu_unsigned = uns;
    cpu_addr     = addr;
    cpu_wdata    = wdata;
    cpu_req      = 1'b1;
    tick();
    cpu_req = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (!cpu_done && !cpu_error && n < 12) begin
      tick();
      n++;
    end
    check(tag, {30'h0, cpu_error, cpu_done}, 32'h1);
  endtask

  task automatic access(input string tag, input logic we, input logic [1:0] size,
                        input logic uns, input logic [9:0] addr, input logic [31:0] wdata);
    start_req(we, size, uns, addr, wdata);
    wait_done(tag);
  endtask

  task automatic fault_req(input string tag, input logic [1:0] size, input logic [9:0] addr,
                           input logic [31:0] rdata_exp);
    start_req(1'b0, size, 1'b0, addr, 32'h0);
    check({tag, "_err"}, {31'h0, cpu_error}, 32'h1);
    check({tag, "_en"}, {31'h0, mem_enable}, 32'h0);
    tick();
    check({tag, "_idle"}, {29'h0, cpu_busy, cpu_error, mem_enable}, 32'h0);
    check({tag, "_rdata"}, cpu_rdata, rdata_exp);
  endtask

  initial begin
    passed       = 0;
    total        = 0;
    rst          = 1'b1;
    mem_clear    = 1'b1;
    mem_stall    = 1'b0;
    ready_delay  = 0;
    cpu_req      = 1'b0;
    cpu_we       = 1'b0;
    cpu_size     = 2'b00;
    cpu_unsigned = 1'b0;
    cpu_addr     = 10'h0;
    cpu_wdata    = 32'h0;
    #1;
    check("rst_ctrl", {27'h0, cpu_busy, cpu_done, cpu_error, mem_enable, 1'b0}, 32'h0);
    check("rst_rdata", cpu_rdata, 32'h0);
    check("rst_mem", {20'h0, mem_wr, mem_addr}, 32'h0);
    check("rst_wdata", mem_data_in, 32'h0);
    tick();
    tick();
    rst       = 1'b0;
    mem_clear = 1'b0;
    tick();

    // Byte store at 0x01, minimum latency.
    start_req(1'b1, 2'b00, 1'b0, 10'h001, 32'h0000_00A5);
    check("bst_en", {31'h0, mem_enable}, 32'h1);
    check("bst_addr", {24'h0, mem_addr}, 32'h0);
    check("bst_wr", {28'h0, mem_wr}, 32'h2);
    check("bst_data", mem_data_in, 32'hA5A5_A5A5);
    check("bst_busy", {30'h0, cpu_busy, cpu_done}, 32'h2);
    tick();
    check("bst_done", {29'h0, cpu_done, cpu_error, mem_enable}, 32'h4);
    check("bst_rdata", cpu_rdata, 32'h0);
    tick();
    check("bst_pulse", {30'h0, cpu_done, cpu_busy}, 32'h0);

    // Word store then loads issued back to back.
    start_req(1'b1, 2'b10, 1'b0, 10'h008, 32'h80FF_7F01);
    check("wst_wr", {20'h0, mem_wr, mem_addr}, 32'hF02);
    check("wst_data", mem_data_in, 32'h80FF_7F01);
    wait_done("wst_done");
    start_req(1'b0, 2'b00, 1'b0, 10'h00B, 32'hFFFF_FFFF);
    check("lb_wr", {20'h0, mem_wr, mem_addr}, 32'h002);
    check("lb_data", mem_data_in, 32'h0);
    wait_done("lb_done");
    check("lb_signed", cpu_rdata, 32'hFFFF_FF80);
    access("lhu_done", 1'b0, 2'b01, 1'b1, 10'h00A, 32'h0);
    check("lhu", cpu_rdata, 32'h0000_80FF);
    access("lh_done", 1'b0, 2'b01, 1'b0, 10'h008, 32'h0);
    check("lh", cpu_rdata, 32'h0000_7F01);
    access("lb9_done", 1'b0, 2'b00, 1'b0, 10'h009, 32'h0);
    check("lb9", cpu_rdata, 32'h0000_007F);
    access("lbuA_done", 1'b0, 2'b00, 1'b1, 10'h00A, 32'h0);
    check("lbuA", cpu_rdata, 32'h0000_00FF);
    access("lhA_done", 1'b0, 2'b01, 1'b0, 10'h00A, 32'h0);
    check("lhA", cpu_rdata, 32'hFFFF_80FF);
    access("lw_done", 1'b0, 2'b10, 1'b0, 10'h008, 32'h0);
    check("lw", cpu_rdata, 32'h80FF_7F01);
    access("st_keep_done", 1'b1, 2'b01, 1'b0, 10'h012, 32'h0000_1234);
    check("st_keep_rdata", cpu_rdata, 32'h80FF_7F01);
    tick();

    // Misaligned and illegal requests.
    fault_req("mis_h", 2'b01, 10'h003, 32'h80FF_7F01);
    fault_req("mis_w", 2'b10, 10'h006, 32'h80FF_7F01);
    fault_req("ill_sz", 2'b11, 10'h000, 32'h80FF_7F01);

    // Timeout with a silent memory.
    mem_stall = 1'b1;
    start_req(1'b0, 2'b00, 1'b0, 10'h008, 32'h0);
    for (int i = 1; i < 4; i++) begin
      check("tmo_wait", {30'h0, mem_enable, cpu_error}, 32'h2);
      tick();
    end
    check("tmo_wait4", {30'h0, mem_enable, cpu_error}, 32'h2);
    tick();
    check("tmo_err", {29'h0, cpu_error, cpu_done, mem_enable}, 32'h4);
    check("tmo_rdata", cpu_rdata, 32'h80FF_7F01);
    tick();
    check("tmo_idle", {30'h0, cpu_busy, cpu_error}, 32'h0);

    // Ready on the final permitted edge wins.
    mem_stall   = 1'b0;
    ready_delay = 3;
    start_req(1'b0, 2'b01, 1'b1, 10'h008, 32'h0);
    tick();
    tick();
    tick();
    check("tw_wait", {30'h0, mem_enable, cpu_done}, 32'h2);
    tick();
    check("tw_done", {30'h0, cpu_done, cpu_error}, 32'h2);
    check("tw_rdata", cpu_rdata, 32'h0000_7F01);
    tick();

    // Wait states with a request raised during the access.
    ready_delay = 2;
    start_req(1'b1, 2'b00, 1'b0, 10'h005, 32'h0000_003C);
    cpu_req   = 1'b1;
    cpu_we    = 1'b1;
    cpu_size  = 2'b10;
    cpu_addr  = 10'h00C;
    cpu_wdata = 32'hDEAD_BEEF;
    for (int i = 0; i < 2; i++) begin
      check("ws_en", {31'h0, mem_enable}, 32'h1);
      check("ws_hold", {20'h0, mem_wr, mem_addr}, 32'h201);
      check("ws_data", mem_data_in, 32'h3C3C_3C3C);
      tick();
    end
    cpu_req = 1'b0;
    check("ws_stable", {20'h0, mem_wr, mem_addr}, 32'h201);
    tick();
    check("ws_done", {29'h0, cpu_done, cpu_error, mem_enable}, 32'h4);
    tick();
    check("ws_no_queue", {29'h0, cpu_busy, cpu_done, mem_enable}, 32'h0);
    ready_delay = 0;
    access("ws_rb_done", 1'b0, 2'b00, 1'b1, 10'h005, 32'h0);
    check("ws_rb", cpu_rdata, 32'h0000_003C);
    access("ws_c_done", 1'b0, 2'b10, 1'b0, 10'h00C, 32'h0);
    check("ws_c", cpu_rdata, 32'h0);
    access("ws_lw_done", 1'b0, 2'b10, 1'b0, 10'h008, 32'h0);
    tick();

    // Reset in the middle of an access.
    mem_stall = 1'b1;
    start_req(1'b0, 2'b10, 1'b0, 10'h008, 32'h0);
    tick();
    check("rm_pre", {30'h0, mem_enable, cpu_busy}, 32'h3);
    rst = 1'b1;
    #1;
    check("rm_ctrl", {28'h0, mem_enable, cpu_busy, cpu_done, cpu_error}, 32'h0);
    check("rm_rdata", cpu_rdata, 32'h0);
    tick();
    rst       = 1'b0;
    mem_stall = 1'b0;
    tick();
    check("rm_quiet", {30'h0, cpu_done, cpu_error}, 32'h0);
    access("rm_lw_done", 1'b0, 2'b10, 1'b0, 10'h000, 32'h0);
    check("rm_lw", cpu_rdata, 32'h0000_A500);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
